pz_coeff_regfile: RTL and testbench
===================================

# pz_coeff_regfile

AXI-Lite register file holding the pole/zero coefficient set for the pixel pipeline, parametrised in entry count, with byte strobes, SLVERR on bad accesses, and frame-synchronous commit of a shadow bank to the active bank. It sits between the AXI-Lite interconnect and the per-entry complex_sub/atan_lut/log_mag_calc array and the pz_accumulators. Active outputs change only at a frame boundary, so a frame never mixes old and new coefficients.

## Interface
- NUM_PZ, 8, number of pole/zero entries, 1..32.
- ADDR_WIDTH, 8, AXI-Lite address width; requires 0x10+4*NUM_PZ ≤ 2^ADDR_WIDTH.
- aclk  in  1  the single clock; AXI-Lite and pipeline side both run on it.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axi_lite_awaddr / awvalid / awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
- s_axi_lite_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel.
- s_axi_lite_bresp / bvalid / bready  out/out/in  2/1/1  write response.
- s_axi_lite_araddr / arvalid / arready  in/in/out  ADDR_WIDTH/1/1  read address.
- s_axi_lite_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data.
- frame_start  in  1  one-cycle pulse, first pixel of a frame accepted (sof & ready).
- pz_flat  out  32*NUM_PZ  active entries; entry i at [32i+:32], {re[31:16], im[15:0]} signed Q-format.
- no_z  out  8  active zero count.
- no_p  out  8  active pole count.
- commit_pulse  out  1  high for one cycle after a commit.

## Operation
- Register map (word address = addr[ADDR_WIDTH-1:2]): 0x00 CTRL: bit0 COMMIT_REQ (write 1 sets pending; reads return pending), bit1 AUTO (commit at every frame_start). 0x04 COUNT: [7:0] no_z, [15:8] no_p (shadow). 0x08 STATUS (RO): bit0 pending, [31:16] commit counter, wraps at 0xFFFF→0. 0x10+4i: shadow entry i.
- Reads of COUNT/entries return shadow contents, not active.
- Write FSM: W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP. IDLE accepts AW and W independently or together; register updated at the edge both are held; next state W_RESP; W_RESP→W_IDLE on bready.
- Read FSM: R_IDLE, R_DATA. ar handshake latches address and data; R_DATA holds rdata/rresp until rready.
- wstrb: byte lanes with strobe 0 unchanged; CTRL/COUNT likewise.
- SLVERR (2'b10): address above last entry, write to STATUS, or COUNT write with no_z+no_p > NUM_PZ; register unchanged, rdata 0 on bad read. Otherwise OKAY.
- Commit: on frame_start with (pending | AUTO): active entries and counts ← shadow, pending ← 0, commit counter +1, commit_pulse next cycle. frame_start with neither: nothing.
- Simultaneous: CTRL write setting COMMIT_REQ on same edge as frame_start → pending set, commit waits for next frame_start. Entry write on same edge as commit → active gets old shadow value, shadow gets new.
- Reset (async): all shadow/active entries 0, counts 0, CTRL 0, STATUS 0, both FSMs idle. Mid-transaction reset abandons the transaction with no response.

## Timing
- During reset all outputs 0; after release awready=wready=arready=1 in idle.
- awready high in W_IDLE/W_WAIT_ADDR; wready high in W_IDLE/W_WAIT_DATA.
- bvalid asserted the cycle after the completing AW/W handshake; rvalid the cycle after ar handshake; arready low in R_DATA.
- Active outputs update on the frame_start edge; commit_pulse 1 cycle later, exactly 1 cycle wide.
- Shadow write visible to read-back one cycle after the write edge.

## Configuration
- PZ_SHADOW_EN defined: double-buffered as above.
- Undefined: no shadow bank; writes land directly in active registers, COMMIT_REQ/AUTO read 0 and are ignored, commit_pulse tied 0, STATUS counter stays 0.

## Test plan
- Reset, write entry 2 = 0x0100_FF00, read back → rdata 0x0100FF00 OKAY; pz_flat[95:64] stays 0 until CTRL=1 then frame_start → 0x0100FF00, commit_pulse one cycle, STATUS=0x00010000.
- W before AW by 3 cycles, bready held low 5 cycles → bvalid stays high, single write, bresp OKAY.
- wstrb=4'b0010 wdata=0xAABBCCDD onto entry 0 = 0x11223344 → 0x1122CC44.
- Read 0x10+4*NUM_PZ → rresp SLVERR rdata 0; COUNT write no_z=6,no_p=3 (NUM_PZ=8) → SLVERR, COUNT unchanged.
- COMMIT_REQ write coincident with frame_start → no commit; next frame_start commits.
- aresetn low mid-write (after AW, before W) → no bvalid, all outputs 0, fresh write then succeeds.

Source files
------------

// File: rtl/pz_coeff_regfile.sv
// AXI-Lite pole/zero coefficient register file with byte strobes, SLVERR decode and frame-synchronous commit.
// Define PZ_SHADOW_EN for a shadow bank committed at frame_start; otherwise writes land directly in the active bank.
module pz_coeff_regfile #(
    parameter int NUM_PZ     = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_lite_awaddr,
    input  logic                  s_axi_lite_awvalid,
    output logic                  s_axi_lite_awready,
    input  logic [31:0]           s_axi_lite_wdata,
    input  logic [3:0]            s_axi_lite_wstrb,
    input  logic                  s_axi_lite_wvalid,
    output logic                  s_axi_lite_wready,
    output logic [1:0]            s_axi_lite_bresp,
    output logic                  s_axi_lite_bvalid,
    input  logic                  s_axi_lite_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_lite_araddr,
    input  logic                  s_axi_lite_arvalid,
    output logic                  s_axi_lite_arready,
    output logic [31:0]           s_axi_lite_rdata,
    output logic [1:0]            s_axi_lite_rresp,
    output logic                  s_axi_lite_rvalid,
    input  logic                  s_axi_lite_rready,
    input  logic                  frame_start,
    output logic [32*NUM_PZ-1:0]  pz_flat,
    output logic [7:0]            no_z,
    output logic [7:0]            no_p,
    output logic                  commit_pulse
);
    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam logic [WORD_W-1:0] WORD_CTRL   = WORD_W'(0);
    localparam logic [WORD_W-1:0] WORD_COUNT  = WORD_W'(1);
    localparam logic [WORD_W-1:0] WORD_STATUS = WORD_W'(2);
    localparam logic [WORD_W-1:0] WORD_LAST   = WORD_W'(4 + NUM_PZ - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        return res;
    endfunction

    wstate_t           wstate_reg, wstate_next;
    rstate_t           rstate_reg, rstate_next;
    logic              ready_en_reg;
    logic [WORD_W-1:0] awword_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;
    logic [1:0]        bresp_reg;
    logic [31:0]       rdata_reg;
    logic [1:0]        rresp_reg;

    logic              aw_hs, w_hs, ar_hs, wr_fire, wr_err, rd_err;
    logic [WORD_W-1:0] wr_word, rd_word;
    logic [31:0]       wr_data, count_merged, rd_val, ctrl_rd, status_rd;
    logic [3:0]        wr_strb;

    logic [31:0]       wbank_reg [NUM_PZ];
    logic [7:0]        wz_reg, wp_reg;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0], count_merged[31:16]};

    // Readies stay low until the first edge after reset release so all outputs are 0 during reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ready_en_reg <= 1'b0;
        else          ready_en_reg <= 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) wstate_reg <= W_IDLE;
        else          wstate_reg <= wstate_next;
    end

    always_comb begin
        wstate_next = wstate_reg;
        case (wstate_reg)
            W_IDLE: begin
                if (aw_hs && w_hs) wstate_next = W_RESP;
                else if (aw_hs)    wstate_next = W_WAIT_DATA;
                else if (w_hs)     wstate_next = W_WAIT_ADDR;
            end
            W_WAIT_DATA: if (w_hs)  wstate_next = W_RESP;
            W_WAIT_ADDR: if (aw_hs) wstate_next = W_RESP;
            W_RESP:      if (s_axi_lite_bready) wstate_next = W_IDLE;
            default:     wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_lite_awready = ready_en_reg && (wstate_reg == W_IDLE || wstate_reg == W_WAIT_ADDR);
        s_axi_lite_wready  = ready_en_reg && (wstate_reg == W_IDLE || wstate_reg == W_WAIT_DATA);
        s_axi_lite_bvalid  = (wstate_reg == W_RESP);
        s_axi_lite_bresp   = bresp_reg;
        aw_hs   = s_axi_lite_awvalid && s_axi_lite_awready;
        w_hs    = s_axi_lite_wvalid && s_axi_lite_wready;
        wr_fire = (wstate_reg == W_IDLE && aw_hs && w_hs) ||
                  (wstate_reg == W_WAIT_DATA && w_hs) ||
                  (wstate_reg == W_WAIT_ADDR && aw_hs);
    end

    // The write completes on the edge where the later of AW/W is accepted; pick the latched half.
    always_comb begin
        wr_word = (wstate_reg == W_WAIT_DATA) ? awword_reg : s_axi_lite_awaddr[ADDR_WIDTH-1:2];
        wr_data = (wstate_reg == W_WAIT_ADDR) ? wdata_reg : s_axi_lite_wdata;
        wr_strb = (wstate_reg == W_WAIT_ADDR) ? wstrb_reg : s_axi_lite_wstrb;
        count_merged = apply_strb({16'h0, wp_reg, wz_reg}, wr_data, wr_strb);
        wr_err = (wr_word == WORD_STATUS) || (wr_word > WORD_LAST) ||
                 ((wr_word == WORD_COUNT) &&
                  (({1'b0, count_merged[7:0]} + {1'b0, count_merged[15:8]}) > 9'(NUM_PZ)));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awword_reg <= '0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
            bresp_reg  <= RESP_OKAY;
        end else begin
            if (aw_hs) awword_reg <= s_axi_lite_awaddr[ADDR_WIDTH-1:2];
            if (w_hs) begin
                wdata_reg <= s_axi_lite_wdata;
                wstrb_reg <= s_axi_lite_wstrb;
            end
            if (wr_fire) bresp_reg <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Host-writable bank: the shadow bank when double-buffered, the active bank otherwise.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_PZ; i++) wbank_reg[i] <= '0;
            wz_reg <= '0;
            wp_reg <= '0;
        end else if (wr_fire && !wr_err) begin
            if (wr_word == WORD_COUNT) begin
                wz_reg <= count_merged[7:0];
                wp_reg <= count_merged[15:8];
            end
            for (int i = 0; i < NUM_PZ; i++)
                if (wr_word == WORD_W'(4 + i))
                    wbank_reg[i] <= apply_strb(wbank_reg[i], wr_data, wr_strb);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rstate_reg <= R_IDLE;
        else          rstate_reg <= rstate_next;
    end

    always_comb begin
        rstate_next = rstate_reg;
        case (rstate_reg)
            R_IDLE:  if (ar_hs) rstate_next = R_DATA;
            R_DATA:  if (s_axi_lite_rready) rstate_next = R_IDLE;
            default: rstate_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_lite_arready = ready_en_reg && (rstate_reg == R_IDLE);
        s_axi_lite_rvalid  = (rstate_reg == R_DATA);
        s_axi_lite_rdata   = rdata_reg;
        s_axi_lite_rresp   = rresp_reg;
        ar_hs = s_axi_lite_arvalid && s_axi_lite_arready;
    end

    always_comb begin
        rd_word = s_axi_lite_araddr[ADDR_WIDTH-1:2];
        rd_val  = '0;
        rd_err  = 1'b0;
        if (rd_word == WORD_CTRL)        rd_val = ctrl_rd;
        else if (rd_word == WORD_COUNT)  rd_val = {16'h0, wp_reg, wz_reg};
        else if (rd_word == WORD_STATUS) rd_val = status_rd;
        else if (rd_word > WORD_LAST)    rd_err = 1'b1;
        else begin
            for (int i = 0; i < NUM_PZ; i++)
                if (rd_word == WORD_W'(4 + i)) rd_val = wbank_reg[i];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata_reg <= '0;
            rresp_reg <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_reg <= rd_val;
            rresp_reg <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    genvar gi;
`ifdef PZ_SHADOW_EN
    logic [31:0] active_reg [NUM_PZ];
    logic [7:0]  az_reg, ap_reg;
    logic        pending_reg, auto_reg, commit_pulse_reg;
    logic [15:0] commit_cnt_reg;
    logic        ctrl_wr, commit_go;

    always_comb begin
        ctrl_wr   = wr_fire && (wr_word == WORD_CTRL) && wr_strb[0];
        commit_go = frame_start && (pending_reg || auto_reg);
    end

    // A COMMIT_REQ landing on a frame_start edge wins over the clear, so it waits for the next frame.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_PZ; i++) active_reg[i] <= '0;
            az_reg           <= '0;
            ap_reg           <= '0;
            pending_reg      <= 1'b0;
            auto_reg         <= 1'b0;
            commit_pulse_reg <= 1'b0;
            commit_cnt_reg   <= '0;
        end else begin
            commit_pulse_reg <= commit_go;
            if (ctrl_wr) auto_reg <= wr_data[1];
            if (ctrl_wr && wr_data[0]) pending_reg <= 1'b1;
            else if (commit_go)        pending_reg <= 1'b0;
            if (commit_go) begin
                for (int i = 0; i < NUM_PZ; i++) active_reg[i] <= wbank_reg[i];
                az_reg         <= wz_reg;
                ap_reg         <= wp_reg;
                commit_cnt_reg <= commit_cnt_reg + 16'd1;
            end
        end
    end

    assign ctrl_rd      = {30'h0, auto_reg, pending_reg};
    assign status_rd    = {commit_cnt_reg, 15'h0, pending_reg};
    assign no_z         = az_reg;
    assign no_p         = ap_reg;
    assign commit_pulse = commit_pulse_reg;
    for (gi = 0; gi < NUM_PZ; gi++) begin : g_flat
        assign pz_flat[32*gi +: 32] = active_reg[gi];
    end
`else
    logic unused_frame;
    assign unused_frame = frame_start;

    assign ctrl_rd      = '0;
    assign status_rd    = '0;
    assign no_z         = wz_reg;
    assign no_p         = wp_reg;
    assign commit_pulse = 1'b0;
    for (gi = 0; gi < NUM_PZ; gi++) begin : g_flat
        assign pz_flat[32*gi +: 32] = wbank_reg[gi];
    end
`endif

endmodule

// File: tb/tb_pz_coeff_regfile.sv
// Randomized bench for pz_coeff_regfile against a register-map level model; follows PZ_SHADOW_EN like the design.
module tb_pz_coeff_regfile;
    localparam int NUM_PZ     = 8;
    localparam int ADDR_WIDTH = 8;
    localparam int FW         = 32*NUM_PZ;
`ifdef PZ_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic                  aclk, aresetn;
    logic [ADDR_WIDTH-1:0] awaddr, araddr;
    logic                  awvalid, awready, wvalid, wready, bvalid, bready;
    logic                  arvalid, arready, rvalid, rready;
    logic [31:0]           wdata, rdata;
    logic [3:0]            wstrb;
    logic [1:0]            bresp, rresp;
    logic                  frame_start, commit_pulse;
    logic [FW-1:0]         pz_flat;
    logic [7:0]            no_z, no_p;

    pz_coeff_regfile #(.NUM_PZ(NUM_PZ), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
        .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid),
        .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid),
        .s_axi_lite_arready(arready), .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
        .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready), .frame_start(frame_start),
        .pz_flat(pz_flat), .no_z(no_z), .no_p(no_p), .commit_pulse(commit_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: register map contents as seen by software and by the pixel pipeline.
    logic [31:0] m_sh  [NUM_PZ];
    logic [31:0] m_act [NUM_PZ];
    logic [7:0]  m_sz, m_sp, m_az, m_ap;
    bit          m_pend, m_auto;
    logic [15:0] m_cnt;

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        if (s[0]) r[7:0]   = new_v[7:0];
        if (s[1]) r[15:8]  = new_v[15:8];
        if (s[2]) r[23:16] = new_v[23:16];
        if (s[3]) r[31:24] = new_v[31:24];
        return r;
    endfunction

    function automatic logic [FW-1:0] exp_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < NUM_PZ; i++) f[32*i +: 32] = m_act[i];
        return f;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_PZ; i++) begin m_sh[i] = '0; m_act[i] = '0; end
        m_sz = 0; m_sp = 0; m_az = 0; m_ap = 0; m_pend = 0; m_auto = 0; m_cnt = 0;
    endtask

    task automatic m_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
        int w;
        logic [31:0] cur;
        w = int'(addr[7:2]);
        resp = 2'b00;
        if (w == 2 || w >= 4 + NUM_PZ) resp = 2'b10;
        else if (w == 0) begin
            if (SHADOW && s[0]) begin m_pend = m_pend | d[0]; m_auto = d[1]; end
        end else if (w == 1) begin
            cur = lanes({16'h0, m_sp, m_sz}, d, s);
            if (int'(cur[7:0]) + int'(cur[15:8]) > NUM_PZ) resp = 2'b10;
            else begin m_sz = cur[7:0]; m_sp = cur[15:8]; end
        end else if (w >= 4) m_sh[w-4] = lanes(m_sh[w-4], d, s);
        if (!SHADOW) begin
            for (int i = 0; i < NUM_PZ; i++) m_act[i] = m_sh[i];
            m_az = m_sz; m_ap = m_sp;
        end
    endtask

    task automatic m_read(input logic [7:0] addr, output logic [31:0] d, output logic [1:0] resp);
        int w;
        w = int'(addr[7:2]);
        d = '0; resp = 2'b00;
        if (w == 0)                d = SHADOW ? {30'h0, m_auto, m_pend} : 32'h0;
        else if (w == 1)           d = {16'h0, m_sp, m_sz};
        else if (w == 2)           d = SHADOW ? {m_cnt, 15'h0, m_pend} : 32'h0;
        else if (w >= 4 + NUM_PZ)  resp = 2'b10;
        else if (w >= 4)           d = m_sh[w-4];
    endtask

    task automatic m_frame(output bit pulse);
        pulse = 0;
        if (SHADOW && (m_pend || m_auto)) begin
            for (int i = 0; i < NUM_PZ; i++) m_act[i] = m_sh[i];
            m_az = m_sz; m_ap = m_sp; m_pend = 0; m_cnt = m_cnt + 16'd1; pulse = 1;
        end
    endtask

    task automatic check_outputs();
        chk("pz_flat", pz_flat, exp_flat());
        chk("counts", {no_p, no_z}, {m_ap, m_az});
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, input bit fs,
                             output logic [1:0] resp, output logic pulse_seen);
        bit aw_done, w_done, aw_hs, w_hs, hold_ok, got;
        int c;
        awaddr = addr; wdata = data; wstrb = strb; frame_start = fs;
        aw_done = 0; w_done = 0; c = 0; pulse_seen = 0; resp = 2'bxx;
        while (!(aw_done && w_done) && c < 64) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            @(negedge aclk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge aclk); #1;
            frame_start = 0;
            if (c == 0) pulse_seen = commit_pulse;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            c++;
        end
        awvalid = 0; wvalid = 0;
        chk("wr_handshake", aw_done && w_done, 1);
        chk("bvalid_latency", bvalid, 1);
        hold_ok = 1;
        for (int k = 0; k < b_dly; k++) begin
            @(negedge aclk);
            if (!bvalid) hold_ok = 0;
            @(posedge aclk); #1;
        end
        if (b_dly > 0) chk("bvalid_hold", hold_ok, 1);
        bready = 1; got = 0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge aclk);
            if (bvalid) begin got = 1; resp = bresp; end
            @(posedge aclk); #1;
        end
        bready = 0;
        chk("bresp_seen", got, 1);
        chk("bvalid_drop", bvalid, 0);
    endtask

    task automatic axi_read(input logic [7:0] addr, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        bit hs, got;
        araddr = addr; arvalid = 1; hs = 0;
        for (int c = 0; c < 64 && !hs; c++) begin
            @(negedge aclk);
            hs = arready;
            @(posedge aclk); #1;
        end
        arvalid = 0;
        chk("ar_handshake", hs, 1);
        chk("rvalid_latency", rvalid, 1);
        chk("arready_busy", arready, 0);
        repeat (r_dly) begin @(posedge aclk); #1; end
        rready = 1; got = 0; data = 'x; resp = 'x;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge aclk);
            if (rvalid) begin got = 1; data = rdata; resp = rresp; end
            @(posedge aclk); #1;
        end
        rready = 0;
        chk("rdata_seen", got, 1);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input bit fs,
                            output logic [1:0] resp);
        logic [1:0] er;
        logic p;
        bit ep;
        ep = 0;
        if (fs) m_frame(ep);
        m_write(addr, data, strb, er);
        axi_write(addr, data, strb, aw_dly, w_dly, b_dly, fs, resp, p);
        $display("WR a=%02h d=%08h s=%h fs=%0d resp=%0d", addr, data, strb, fs, resp);
        if (fs) chk("fs_coincident_pulse", p, ep);
        chk("bresp", resp, er);
        check_outputs();
    endtask

    task automatic do_read(input logic [7:0] addr, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
        logic [31:0] ed;
        logic [1:0]  er;
        m_read(addr, ed, er);
        axi_read(addr, r_dly, data, resp);
        $display("RD a=%02h d=%08h resp=%0d", addr, data, resp);
        chk("rdata", data, ed);
        chk("rresp", resp, er);
    endtask

    task automatic do_frame();
        bit ep;
        m_frame(ep);
        frame_start = 1;
        @(posedge aclk); #1;
        frame_start = 0;
        $display("FRAME commit_pulse=%0d", commit_pulse);
        chk("commit_pulse", commit_pulse, ep);
        check_outputs();
        @(posedge aclk); #1;
        chk("pulse_width", commit_pulse, 0);
    endtask

    task automatic do_reset();
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; frame_start = 0;
        aresetn = 0;
        repeat (2) @(posedge aclk);
        #1;
        $display("RESET");
        chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, commit_pulse,
                              bresp, rresp, rdata, no_z, no_p}, 0);
        chk("reset_flat", pz_flat, 0);
        aresetn = 1;
        m_reset();
        repeat (2) @(posedge aclk);
        #1;
        chk("idle_ready", {awready, wready, arready, bvalid}, 4'b1110);
    endtask

    logic [31:0] d;
    logic [1:0]  r;

    initial begin
        aresetn = 1; awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; frame_start = 0;
        #1;
        do_reset();

        // Entry write, read back, commit via COMMIT_REQ, STATUS counter.
        do_write(8'h18, 32'h0100FF00, 4'hF, 0, 0, 0, 0, r);
        do_read(8'h18, 0, d, r);
        chk("entry2_readback", d, 32'h0100FF00);
        do_write(8'h00, 32'h1, 4'hF, 0, 0, 0, 0, r);
        do_frame();
        do_read(8'h08, 0, d, r);

        // W leads AW by 3 cycles, bready held off 5 cycles; then a single-lane strobe.
        do_write(8'h10, 32'h11223344, 4'hF, 3, 0, 5, 0, r);
        do_write(8'h10, 32'hAABBCCDD, 4'b0010, 0, 0, 0, 0, r);
        do_read(8'h10, 1, d, r);
        chk("strobe_merge", d, 32'h1122CC44);

        // Out-of-range read and an oversubscribed COUNT write.
        do_read(8'h30, 0, d, r);
        chk("oob_read_resp", {r, d}, {2'b10, 32'h0});
        do_write(8'h04, 32'h0302, 4'hF, 0, 0, 0, 0, r);
        do_write(8'h04, 32'h0306, 4'hF, 0, 0, 0, 0, r);
        chk("count_over_resp", r, 2'b10);
        do_read(8'h04, 0, d, r);
        chk("count_unchanged", d, 32'h0302);
        do_write(8'h08, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0, r);

        // COMMIT_REQ on the frame_start edge defers to the next frame.
        do_write(8'h1C, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, r);
        do_write(8'h00, 32'h1, 4'hF, 0, 0, 0, 1, r);
        do_read(8'h08, 0, d, r);
        do_frame();

        // Entry write on the commit edge: active takes the old shadow value.
        do_write(8'h00, 32'h1, 4'hF, 0, 0, 0, 0, r);
        do_write(8'h20, 32'h12345678, 4'hF, 0, 0, 0, 1, r);
        do_read(8'h20, 0, d, r);
        do_frame();
        do_write(8'h00, 32'h2, 4'h1, 0, 0, 0, 0, r);
        do_frame();
        do_frame();
        do_write(8'h00, 32'h0, 4'h1, 0, 0, 0, 0, r);

        // Reset while waiting for W: transaction abandoned, then a fresh write works.
        awaddr = 8'h14; awvalid = 1;
        begin
            bit hs;
            @(negedge aclk);
            hs = awready;
            @(posedge aclk); #1;
            awvalid = 0;
            chk("midwrite_aw_accepted", hs, 1);
            chk("midwrite_wait_data", {awready, wready}, 2'b01);
        end
        do_reset();
        do_write(8'h14, 32'hCAFE0001, 4'hF, 0, 2, 0, 0, r);
        do_read(8'h14, 0, d, r);

        for (int n = 0; n < 200; n++) begin
            int op, w;
            logic [7:0] a;
            logic [31:0] dd;
            op = int'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) w = int'($urandom_range(0, 63));
            else                           w = int'($urandom_range(0, 5 + NUM_PZ));
            a = {6'(w), 2'($urandom_range(0, 3))};
            dd = $urandom();
            if (w == 1) begin
                dd[7:0]  = 8'($urandom_range(0, NUM_PZ));
                dd[15:8] = 8'($urandom_range(0, NUM_PZ));
            end
            if (op < 5)
                do_write(a, dd, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0, r);
            else if (op < 8)
                do_read(a, int'($urandom_range(0, 2)), d, r);
            else
                do_frame();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
